spi_txn_arbiter: RTL and testbench

//  Shares one SPI master bus (SCLK/MOSI/MISO/CS_N) between two requesters.

---
 rtl/spi_txn_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one mode-0 SPI master between two requesters.
// Each granted transaction runs one full-duplex DATA_W-bit frame, MSB first.
module spi_txn_arbiter #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] TXD0,
  output logic              GNT0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] TXD1,
  output logic              GNT1,
  output logic [DATA_W-1:0] RXD,
  output logic              DONE,
  output logic              DONE_ID,
  output logic              BUSY,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_N
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                done_q, done_d, done_id_q, done_id_d;
  logic                busy_q, busy_d, sclk_q, sclk_d;
  logic                mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic                last_q, last_d, sel_q, sel_d;
  logic [DATA_W-1:0]   rxd_q, rxd_d;
  logic [DATA_W-1:0]   tx_q, rx_q, tx_sel;
  logic                cnt_end, arb_ok, pick1;
  logic                load_tx, shift_tx, shift_rx;

  assign cnt_end = (cnt_q == CNT_LAST);
  // Arbitration happens in plain IDLE and on the last GAP edge, so a waiting
  // requester's grant lands in the first cycle after GAP.
  assign arb_ok  = ((state_q == IDLE) && !gnt0_q && !gnt1_q) ||
                   ((state_q == GAP) && cnt_end);
  assign pick1   = REQ1 && (!REQ0 || !last_q);
  assign tx_sel  = gnt1_q ? TXD1 : TXD0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_end ? '0 : cnt_q + CNT_W'(1);
    half_d    = half_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    last_d    = last_q;
    sel_d     = sel_q;
    rxd_d     = rxd_q;
    load_tx   = 1'b0;
    shift_tx  = 1'b0;
    shift_rx  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The grant cycle itself: TXD is captured at its closing edge.
        if (gnt0_q || gnt1_q) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = tx_sel[DATA_W-1];
          cnt_d   = '0;
          load_tx = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_end) begin
          state_d = SHIFT;
          half_d  = '0;
        end
      end
      SHIFT: begin
        if (cnt_end) begin
          if (half_q == HALF_LAST) begin
            state_d = HOLD;
            sclk_d  = 1'b0;
          end else begin
            half_d = half_q + HALF_W'(1);
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              shift_rx = 1'b1;
            end else begin
              shift_tx = 1'b1;
              mosi_d   = tx_q[DATA_W-2];
            end
          end
        end
      end
      HOLD: begin
        if (cnt_end) begin
          state_d   = GAP;
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rxd_d     = rx_q;
          done_id_d = sel_q;
          last_d    = sel_q;
        end
      end
      GAP: begin
        if (cnt_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_ok && (REQ0 || REQ1)) begin
      state_d = IDLE;
      gnt0_d  = !pick1;
      gnt1_d  = pick1;
      sel_d   = pick1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      rxd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      rxd_q     <= rxd_d;
    end
  end

  // Shift registers carry only data and are fully rewritten every frame.
  always_ff @(posedge CLK) begin
    if (load_tx) begin
      tx_q <= tx_sel;
    end else if (shift_tx) begin
      tx_q <= {tx_q[DATA_W-2:0], 1'b0};
    end
    if (shift_rx) begin
      rx_q <= {rx_q[DATA_W-2:0], MISO};
    end
  end

  assign GNT0    = gnt0_q;
  assign GNT1    = gnt1_q;
  assign RXD     = rxd_q;
  assign DONE    = done_q;
  assign DONE_ID = done_id_q;
  assign BUSY    = busy_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign CS_N    = cs_n_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_spi_txn_arbiter;

  localparam int DW0  = 8;
  localparam int CD0  = 2;
  localparam int LAT0 = 2 * CD0 * (DW0 + 1) + 1;
  localparam int DW1  = 16;
  localparam int CD1  = 1;
  localparam int LAT1 = 2 * CD1 * (DW1 + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [DW0-1:0] txd0 = '0, txd1 = '0, rxd;
  logic gnt0, gnt1, done, done_id, busy, sclk, mosi, cs_n;
  logic miso = 1'b0;

  logic b_req0 = 1'b0;
  logic [DW1-1:0] b_txd0 = '0, b_rxd;
  logic b_gnt0, b_gnt1, b_done, b_done_id, b_busy, b_sclk, b_mosi, b_cs_n;

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  logic [DW0-1:0] slv_word = '0;
  logic [DW0-1:0] mosi_cap = '0;
  int   nrise = 0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1;

  spi_txn_arbiter #(.DATA_W(DW0), .CLK_DIV(CD0)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .TXD0(txd0), .GNT0(gnt0),
    .REQ1(req1), .TXD1(txd1), .GNT1(gnt1),
    .RXD(rxd), .DONE(done), .DONE_ID(done_id), .BUSY(busy),
    .SCLK(sclk), .MOSI(mosi), .MISO(miso), .CS_N(cs_n)
  );

  spi_txn_arbiter #(.DATA_W(DW1), .CLK_DIV(CD1)) dut_fast (
    .CLK(clk), .RST(rst),
    .REQ0(b_req0), .TXD0(b_txd0), .GNT0(b_gnt0),
    .REQ1(1'b0), .TXD1(16'h0000), .GNT1(b_gnt1),
    .RXD(b_rxd), .DONE(b_done), .DONE_ID(b_done_id), .BUSY(b_busy),
    .SCLK(b_sclk), .MOSI(b_mosi), .MISO(1'b0), .CS_N(b_cs_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave: presents the next MISO bit while SCLK is low, records MOSI
  // on each SCLK rising edge.
  always @(negedge clk) begin
    if (!cs_n && prev_cs) begin
      mosi_cap = '0;
      nrise    = 0;
    end
    if (!cs_n) begin
      if (sclk && !prev_sclk) begin
        mosi_cap = {mosi_cap[DW0-2:0], mosi};
        nrise++;
      end
      miso = (nrise < DW0) ? slv_word[DW0-1-nrise] : 1'b0;
    end else begin
      miso = 1'b0;
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_gnt(output logic [1:0] g, output int n);
    g = 2'b00;
    n = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        g = {gnt0, gnt1};
        n = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        n = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic           r0, r1;
    logic [DW0-1:0] t0, t1, sw;
    logic [1:0]     eg;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [1:0] g, exp_g;
    int n, d, n2, cnt;
    logic seen0, seen1, last, in_frame, cur_id, chg0, chg1, stop;
    logic [DW0-1:0] exp_txd;
    int exp_done, elig, rises, highs;
    logic pb;

    // {REQ0, REQ1, TXD0, TXD1, slave word, expected {GNT0,GNT1}}
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'h3C, 2'b10};
    tbl[1] = '{1'b1, 1'b1, 8'h11, 8'h5A, 8'hC3, 2'b01};
    tbl[2] = '{1'b1, 1'b1, 8'hFF, 8'h22, 8'h00, 2'b10};
    tbl[3] = '{1'b0, 1'b1, 8'h33, 8'h00, 8'hFF, 2'b01};
    tbl[4] = '{1'b0, 1'b1, 8'h44, 8'h81, 8'h7E, 2'b01};
    tbl[5] = '{1'b1, 1'b1, 8'h96, 8'h55, 8'h69, 2'b10};
    tbl[6] = '{1'b1, 1'b0, 8'h01, 8'h66, 8'h80, 2'b10};
    tbl[7] = '{1'b1, 1'b1, 8'h77, 8'hE7, 8'h18, 2'b01};

    repeat (3) @(negedge clk);
    chk("rst_csn",  {31'd0, cs_n}, 32'd1);
    chk("rst_sclk_mosi", {30'd0, sclk, mosi}, 32'd0);
    chk("rst_outs", {28'd0, gnt0, gnt1, done, busy}, 32'd0);
    chk("rst_rxd",  {23'd0, rxd, done_id}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wait_idle();
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      txd0 = tbl[i].t0; txd1 = tbl[i].t1;
      slv_word = tbl[i].sw;
      wait_gnt(g, n);
      chk($sformatf("tbl%0d_gnt", i), {30'd0, g}, {30'd0, tbl[i].eg});
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      txd0 = ~txd0; txd1 = ~txd1;
      wait_done(d);
      chk($sformatf("tbl%0d_latency", i), d - n, LAT0);
      chk($sformatf("tbl%0d_rxd", i), {24'd0, rxd}, {24'd0, tbl[i].sw});
      chk($sformatf("tbl%0d_done_id", i), {31'd0, done_id}, {31'd0, tbl[i].eg[0]});
      chk($sformatf("tbl%0d_mosi", i), {24'd0, mosi_cap},
          {24'd0, tbl[i].eg[1] ? tbl[i].t0 : tbl[i].t1});
    end

    // REQ0 raised while requester 1 is being served
    wait_idle();
    req1 = 1'b1; txd1 = 8'hC6; slv_word = 8'h5D;
    wait_gnt(g, n);
    chk("late_gnt1", {30'd0, g}, 32'd1);
    req1 = 1'b0;
    repeat (10) @(negedge clk);
    req0 = 1'b1; txd0 = 8'h0F;
    wait_done(d);
    chk("late_done_id", {31'd0, done_id}, 32'd1);
    chk("late_rxd", {24'd0, rxd}, 32'h5D);
    wait_gnt(g, n2);
    chk("late_gnt0", {30'd0, g}, 32'd2);
    chk("late_gnt_gap", n2 - d, CD0);
    req0 = 1'b0;
    wait_done(d);
    chk("late_mosi", {24'd0, mosi_cap}, 32'h0F);

    // Reset in the middle of SHIFT clears the frame and the RR pointer
    wait_idle();
    req1 = 1'b1; txd1 = 8'h3A;
    wait_gnt(g, n);
    chk("rst_mid_gnt1", {30'd0, g}, 32'd1);
    req1 = 1'b0;
    repeat (15) @(negedge clk);
    chk("rst_mid_pre_csn", {31'd0, cs_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_csn", {31'd0, cs_n}, 32'd1);
    chk("rst_mid_sclk_busy", {30'd0, sclk, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("rst_mid_no_done", cnt, 0);
    req0 = 1'b1; req1 = 1'b1; txd0 = 8'hB4;
    wait_gnt(g, n);
    chk("rst_mid_rr", {30'd0, g}, 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    wait_done(d);
    chk("rst_mid_done_id", {31'd0, done_id}, 32'd0);

    // Randomized traffic against a transaction-level model
    wait_idle();
    last = 1'b0; in_frame = 1'b0; cur_id = 1'b0; elig = 0;
    chg0 = 1'b0; chg1 = 1'b0; stop = 1'b0; exp_done = 0; exp_txd = '0;
    for (int i = 0; i < 3400; i++) begin
      @(negedge clk);
      seen0 = req0; seen1 = req1;
      n = cyc;
      g = {gnt0, gnt1};
      exp_g = 2'b00;
      if (!in_frame && n >= elig && (seen0 || seen1))
        exp_g = (seen0 && seen1) ? (last ? 2'b10 : 2'b01) : (seen0 ? 2'b10 : 2'b01);
      if (g != 2'b00 || exp_g != 2'b00) chk("rnd_gnt", {30'd0, g}, {30'd0, exp_g});
      if (g != 2'b00 && g == exp_g) begin
        in_frame = 1'b1;
        cur_id   = g[0];
        exp_done = n + LAT0;
        exp_txd  = g[0] ? txd1 : txd0;
        slv_word = DW0'($urandom);
      end
      if (done) begin
        if (!in_frame) begin
          chk("rnd_spurious_done", {31'd0, done}, 32'd0);
        end else begin
          chk("rnd_latency", n, exp_done);
          chk("rnd_rxd", {24'd0, rxd}, {24'd0, slv_word});
          chk("rnd_done_id", {31'd0, done_id}, {31'd0, cur_id});
          chk("rnd_mosi", {24'd0, mosi_cap}, {24'd0, exp_txd});
          in_frame = 1'b0;
          elig = n + CD0;
          last = cur_id;
        end
      end else if (in_frame && n > exp_done) begin
        chk("rnd_done_timeout", {31'd0, done}, 32'd1);
        in_frame = 1'b0;
        elig = n;
      end
      if (chg0) txd0 = DW0'($urandom);
      if (chg1) txd1 = DW0'($urandom);
      chg0 = g[1]; chg1 = g[0];
      if (i >= 3200) stop = 1'b1;
      if (stop) begin
        req0 = 1'b0; req1 = 1'b0;
        if (!in_frame && !busy) break;
      end else begin
        if (g[1]) req0 = 1'($urandom_range(0, 1));
        else if (!req0 && $urandom_range(0, 15) == 0) begin req0 = 1'b1; txd0 = DW0'($urandom); end
        else if (req0 && $urandom_range(0, 63) == 0) req0 = 1'b0;
        if (g[0]) req1 = 1'($urandom_range(0, 1));
        else if (!req1 && $urandom_range(0, 15) == 0) begin req1 = 1'b1; txd1 = DW0'($urandom); end
        else if (req1 && $urandom_range(0, 63) == 0) req1 = 1'b0;
      end
    end

    // CLK_DIV=1, DATA_W=16 instance with MISO tied low
    @(negedge clk);
    b_req0 = 1'b1; b_txd0 = 16'hFFFF;
    n = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_gnt0) begin n = cyc; break; end
    end
    chk("fast_gnt", {31'd0, b_gnt0}, 32'd1);
    b_req0 = 1'b0;
    d = -1; rises = 0; highs = 0; pb = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (b_sclk) highs++;
      if (b_sclk && !pb) rises++;
      pb = b_sclk;
      if (b_done) begin d = cyc; break; end
    end
    chk("fast_latency", d - n, LAT1);
    chk("fast_rises", rises, DW1);
    chk("fast_high_cycles", highs, DW1);
    chk("fast_rxd", {16'd0, b_rxd}, 32'd0);
    chk("fast_done_id", {31'd0, b_done_id}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
